// File: rtl/ssd_pkg.sv
// Shared constants for seven-segment display paths (scan driver, counter display).
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
//
// Contents:
//   SEG_0..SEG_9, SEG_ERR, SEG_BLANK : active-low segment patterns {g,f,e,d,c,b,a}
//   clog2                            : counter width helper, never returns less than 1
package ssd_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_ERR   = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Bits needed to hold 0..value-1; a 1-bit minimum keeps degenerate counters legal.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) < value) begin
            w = k + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bundle between the digit source and the seven-segment scan driver.
// Latency: n/a (wires only).
// Backpressure: none; the driver samples the digit inputs once per scan frame.
//
// Signals:
//   DIGITS_BCD  BCD digits, [3:0] is digit 0      DP_IN  decimal point per digit, 1 = lit
//   BLANK_LZ    1 = suppress leading zeros         SEG    segments {g,f,e,d,c,b,a}, active-low
//   DP          decimal point, active-low          AN     anode enables, active-low
//   FRAME_TICK  one-cycle pulse per completed scan frame
// master = digit source / display side, slave = scan driver.
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] DIGITS_BCD;
   logic [NUM_DIGITS-1:0]   DP_IN;
   logic                    BLANK_LZ;
   logic [6:0]              SEG;
   logic                    DP;
   logic [NUM_DIGITS-1:0]   AN;
   logic                    FRAME_TICK;

   modport master (
      output DIGITS_BCD, DP_IN, BLANK_LZ,
      input  SEG, DP, AN, FRAME_TICK
   );

   modport slave (
      input  DIGITS_BCD, DP_IN, BLANK_LZ,
      output SEG, DP, AN, FRAME_TICK
   );
endinterface

// File: rtl/ssd_bcd_decode.sv
// BCD to active-low seven-segment decode; codes 10..15 show the "E" glyph.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   bcd  in  4  digit code
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
module ssd_bcd_decode
   import ssd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_ERR;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with per-slot blanking and leading-zero blanking.
// Latency: outputs registered, one cycle behind the slot counters; inputs take effect at the next frame start.
// Backpressure: none; inputs are sampled once per frame and changes between frame starts are ignored.
//
// Ports:
//   CLOCK  in  system clock, rising edge        RESET  in  synchronous reset, active-low
//   bus    slave modport of ssd_scan_driver_if (DIGITS_BCD, DP_IN, BLANK_LZ in; SEG, DP, AN, FRAME_TICK out)
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
)(
   input  logic              CLOCK,
   input  logic              RESET,
   ssd_scan_driver_if.slave  bus
);

   localparam int PW = clog2(REFRESH_DIV);
   localparam int IW = clog2(NUM_DIGITS);

   localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           dig_idx;
   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    shadow_lz;
   logic                    frame_end_q;

   logic                    slot_end;
   logic                    frame_start;
   logic [3:0]              cur_bcd;
   logic [6:0]              dec_seg;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [NUM_DIGITS-1:0]   lz_sup;

   assign slot_end    = (presc == P_LAST);
   assign frame_start = (presc == '0) && (dig_idx == '0);
   assign cur_bcd     = shadow_bcd[{dig_idx, 2'b00} +: 4];

   ssd_bcd_decode u_dec (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

   // Exactly one anode low for the digit currently being scanned.
   always_comb begin
      an_sel          = '1;
      an_sel[dig_idx] = 1'b0;
   end

   // Digit k is a leading zero when it and every more significant digit are zero.
   // Digit 0 is left out so a value of zero still shows a single "0".
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      lz_sup     = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero & (shadow_bcd[4*k +: 4] == 4'd0);
         lz_sup[k]  = upper_zero;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         presc          <= '0;
         dig_idx        <= '0;
         shadow_bcd     <= '0;
         shadow_dp      <= '0;
         shadow_lz      <= 1'b0;
         frame_end_q    <= 1'b0;
         bus.SEG        <= SEG_BLANK;
         bus.DP         <= 1'b1;
         bus.AN         <= '1;
         bus.FRAME_TICK <= 1'b0;
      end else begin
         presc <= slot_end ? '0 : presc + 1'b1;
         if (slot_end) begin
            dig_idx <= (dig_idx == I_LAST) ? '0 : dig_idx + 1'b1;
         end

         // Snapshot once per frame so a single frame never mixes two input values.
         if (frame_start) begin
            shadow_bcd <= bus.DIGITS_BCD;
            shadow_dp  <= bus.DP_IN;
            shadow_lz  <= bus.BLANK_LZ;
         end

         // Last cycle of the last slot is flagged here; the tick goes out on the
         // following cycle (the new frame's first cycle), then registered once more.
         frame_end_q    <= slot_end && (dig_idx == I_LAST);
         bus.FRAME_TICK <= frame_end_q;

         if (presc < P_BLANK) begin
            // Anodes off at the start of every slot so the old digit cannot ghost.
            bus.AN  <= '1;
            bus.SEG <= SEG_BLANK;
            bus.DP  <= 1'b1;
         end else begin
            bus.AN  <= an_sel;
            bus.SEG <= (shadow_lz && lz_sup[dig_idx]) ? SEG_BLANK : dec_seg;
            bus.DP  <= ~shadow_dp[dig_idx];
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a cycle-count reference model predicts every output edge,
// a separate monitor compares the DUT against the predictions on the falling edge.
// Directed scenarios (scan, leading zeros, error glyph, anti-tearing, mid-frame reset) then random traffic.
module tb_ssd_scan_driver;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FR = ND * RD;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;

   always #5 CLOCK = ~CLOCK;

   ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   ssd_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   typedef struct packed {
      logic [6:0]    seg;
      logic          dp;
      logic [ND-1:0] an;
      logic          tick;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Glyph table written straight from the display's digit chart.
   function automatic logic [6:0] glyph(input int v);
      case (v)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b0000110;
      endcase
   endfunction

   // Reference model. c = cycles elapsed since the last reset edge; the scan position,
   // frame boundaries and tick are plain arithmetic on c.
   initial begin
      int            c;
      logic [15:0]   sh_bcd;
      logic [ND-1:0] sh_dp;
      logic          sh_lz;
      exp_t          e;
      c      = 0;
      sh_bcd = '0;
      sh_dp  = '0;
      sh_lz  = 1'b0;
      forever begin
         @(posedge CLOCK);
         // Values sampled here are those held during the cycle this edge ends.
         e = '{seg: 7'h7F, dp: 1'b1, an: '1, tick: 1'b0};
         if (!RESET) begin
            c      = 0;
            sh_bcd = '0;
            sh_dp  = '0;
            sh_lz  = 1'b0;
         end else begin
            int p;
            int i;
            p = c % RD;
            i = (c / RD) % ND;
            if (p >= BC) begin
               e.an    = '1;
               e.an[i] = 1'b0;
               if (sh_lz && i >= 1 && (sh_bcd >> (4 * i)) == 16'd0) begin
                  e.seg = 7'h7F;
               end else begin
                  e.seg = glyph(int'(sh_bcd[4*i +: 4]));
               end
               e.dp = ~sh_dp[i];
            end
            e.tick = (c >= 1) && (((c - 1) % FR) == FR - 1);
            if (c % FR == 0) begin
               sh_bcd = bus.DIGITS_BCD;
               sh_dp  = bus.DP_IN;
               sh_lz  = bus.BLANK_LZ;
            end
            c++;
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: one comparison per output edge plus the single-anode rule.
   initial begin
      int   edge_n;
      exp_t e;
      exp_t got;
      edge_n = 0;
      forever begin
         @(negedge CLOCK);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{seg: bus.SEG, dp: bus.DP, an: bus.AN, tick: bus.FRAME_TICK};
            edge_n++;
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL outputs@edge%0d: got seg=%b dp=%b an=%b tick=%b, expected seg=%b dp=%b an=%b tick=%b",
                        edge_n, got.seg, got.dp, got.an, got.tick, e.seg, e.dp, e.an, e.tick);
            end
            n_checks++;
            if ($countones(~bus.AN) > 1) begin
               n_fail++;
               $display("FAIL one_anode@edge%0d: got an=%b, expected at most one low bit", edge_n, bus.AN);
            end
         end
      end
   end

   task automatic step(input int k);
      repeat (k) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic set_in(input logic [15:0] bcd, input logic [ND-1:0] dp, input logic lz);
      bus.DIGITS_BCD = bcd;
      bus.DP_IN      = dp;
      bus.BLANK_LZ   = lz;
   endtask

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < ND; k++) begin
         // Bias toward zeros so leading-zero blanking gets exercised.
         v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   initial begin
      // Reset held for 3 edges with random inputs.
      RESET = 1'b0;
      set_in(rand_bcd(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      step(3);

      // Scan of 1234, two frames (includes the first frame tick).
      set_in(16'h1234, 4'b0000, 1'b0);
      RESET = 1'b1;
      step(2 * FR);

      // Leading-zero blanking.
      set_in(16'h0050, 4'b0000, 1'b1);
      step(2 * FR);

      // Error glyph and decimal point.
      set_in(16'h00A0, 4'b0010, 1'b0);
      step(2 * FR);

      // Anti-tearing: change inputs while digit 2 is being scanned.
      set_in(16'h1111, 4'b0000, 1'b0);
      step(FR + 2 * RD + 2);
      set_in(16'h2222, 4'b0000, 1'b0);
      step(2 * FR);

      // Mid-frame reset during digit 2's active window, then the 1234 scan again.
      step(2 * RD + 3);
      RESET = 1'b0;
      set_in(rand_bcd(), 4'($urandom_range(0, 15)), 1'b1);
      step(2);
      set_in(16'h1234, 4'b0000, 1'b0);
      RESET = 1'b1;
      step(2 * FR);

      // Random traffic with occasional short resets.
      for (int r = 0; r < 40; r++) begin
         set_in(rand_bcd(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) == 0) begin
            RESET = 1'b0;
            step($urandom_range(1, 2));
            RESET = 1'b1;
         end
         step($urandom_range(1, 50));
      end

      step(2);
      @(negedge CLOCK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
